// File: rtl/controlpath_pkg.sv
// Shared types and encodings for the interrupt-capable CPU control path:
// FSM states, opcodes, jump conditions and datapath source selectors.
package controlpath_pkg;

    typedef enum logic [5:0] {
        st_sample          = 6'd0,
        st_fetch_addr      = 6'd1,
        st_fetch_data      = 6'd2,
        st_decode          = 6'd3,
        st_load_addr       = 6'd4,
        st_load_data       = 6'd5,
        st_store           = 6'd6,
        st_alu             = 6'd7,
        st_alu_imm8        = 6'd8,
        st_alu_imm4        = 6'd9,
        st_push            = 6'd10,
        st_push_inc        = 6'd11,
        st_pop_dec         = 6'd12,
        st_pop_addr        = 6'd13,
        st_pop_data        = 6'd14,
        st_jump            = 6'd15,
        st_jump_link_push  = 6'd16,
        st_jump_link_inc   = 6'd17,
        st_jump_set        = 6'd18,
        st_jump_ret_dec    = 6'd19,
        st_jump_ret_addr   = 6'd20,
        st_jump_ret_set    = 6'd21,
        st_ei_di           = 6'd22,
        st_halt            = 6'd23,
        st_irq_push_pc     = 6'd24,
        st_irq_inc_pc      = 6'd25,
        st_irq_push_sr     = 6'd26,
        st_irq_inc_sr      = 6'd27,
        st_irq_jmp         = 6'd28,
        st_rti_dec_sr      = 6'd29,
        st_rti_addr_sr     = 6'd30,
        st_rti_set_sr      = 6'd31,
        st_rti_dec_pc      = 6'd32,
        st_rti_addr_pc     = 6'd33,
        st_rti_set_pc      = 6'd34
    } state_t;

    localparam logic [3:0] OP_LOAD     = 4'h0;
    localparam logic [3:0] OP_STORE    = 4'h1;
    localparam logic [3:0] OP_ALU_IMM8 = 4'h2;
    localparam logic [3:0] OP_PUSH     = 4'h5;
    localparam logic [3:0] OP_POP      = 4'h6;
    localparam logic [3:0] OP_HALT     = 4'h7;
    localparam logic [3:0] OP_ALU      = 4'h8;
    localparam logic [3:0] OP_ALU_IMM4 = 4'h9;
    localparam logic [3:0] OP_JUMP     = 4'hA;
    localparam logic [3:0] OP_RTI      = 4'hB;
    localparam logic [3:0] OP_EI_DI    = 4'hC;

    localparam logic [3:0] COND_JMP = 4'h0;
    localparam logic [3:0] COND_JZ  = 4'h1;
    localparam logic [3:0] COND_JNZ = 4'h2;
    localparam logic [3:0] COND_JN  = 4'h3;
    localparam logic [3:0] COND_JP  = 4'h4;

    typedef enum logic {
        addr_register_data = 1'b0,
        addr_sp            = 1'b1
    } mem_write_addr_source_t;

    typedef enum logic [1:0] {
        data_register_data = 2'd0,
        data_next_pc       = 2'd1,
        data_this_pc       = 2'd2,
        data_sr            = 2'd3
    } mem_write_data_source_t;

    // Unknown condition codes are never taken.
    function automatic logic jump_taken(input logic [3:0] cond, input logic z, input logic n);
        case (cond)
            COND_JMP: jump_taken = 1'b1;
            COND_JZ:  jump_taken = z;
            COND_JNZ: jump_taken = !z;
            COND_JN:  jump_taken = n;
            COND_JP:  jump_taken = !n && !z;
            default:  jump_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: reports the lowest-index active request line.
module irq_priority_encoder
#(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    index
);

    // Scanning downwards lets the lowest active index overwrite the others.
    always_comb begin
        valid = |req;
        index = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controlpath.sv
// Multicycle control FSM for the 16-bit core with prioritised, vectored
// interrupts, global interrupt enable, rti and halt-with-wakeup.
module irq_controlpath
    import controlpath_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [15:0]            instruction,
    input  logic                   Z,
    input  logic                   N,
    input  logic [NUM_IRQ-1:0]     irq_req,
    output logic [NUM_IRQ-1:0]     irq_ack,
    output logic [ID_W-1:0]        irq_id,
    output logic                   irq_enabled,
    output logic                   halted,
    output logic                   reg_write,
    output logic                   mem_to_reg,
    output logic                   mem_read_is_pc,
    output logic                   mem_read_is_sp,
    output logic                   alu_override_imm8,
    output logic                   alu_override_imm4,
    output logic                   alu_set_flags,
    output logic                   set_pc,
    output logic                   pc_from_register,
    output logic                   pc_from_irq,
    output logic                   pc_from_mem,
    output logic                   sr_from_mem,
    output logic                   set_sp,
    output logic                   increase_sp,
    output logic                   mem_write,
    output mem_write_addr_source_t mem_write_addr_source,
    output mem_write_data_source_t mem_write_data_source,
    output logic [5:0]             state
);

    state_t            state_q, state_d;
    logic              ie_q, ie_d;
    logic              from_halt_q;
    logic [ID_W-1:0]   irq_id_q;
    logic              irq_valid;
    logic [ID_W-1:0]   irq_index;
    logic              take_irq;
    logic [3:0]        opcode;
    logic              taken;
    logic              is_link;
    logic              is_return;
    logic              unused_instruction_bits;

    irq_priority_encoder #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_encoder (
        .req   (irq_req),
        .valid (irq_valid),
        .index (irq_index)
    );

    assign opcode    = instruction[15:12];
    assign is_link   = instruction[4];
    assign is_return = instruction[5];
    assign taken     = jump_taken(instruction[3:0], Z, N);
    assign unused_instruction_bits = ^instruction[11:6];

    // Requests are only ever considered at an instruction boundary or while halted.
    assign take_irq = ie_q && irq_valid && (state_q == st_sample || state_q == st_halt);

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            state_q     <= st_sample;
            ie_q        <= 1'b0;
            irq_id_q    <= '0;
            from_halt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
            if (take_irq) begin
                irq_id_q    <= irq_index;
                from_halt_q <= (state_q == st_halt);
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // skipped an assignment would otherwise infer a latch.
        state_d               = state_q;
        ie_d                  = ie_q;
        reg_write             = 1'b0;
        mem_to_reg            = 1'b0;
        mem_read_is_pc        = 1'b0;
        mem_read_is_sp        = 1'b0;
        alu_override_imm8     = 1'b0;
        alu_override_imm4     = 1'b0;
        alu_set_flags         = 1'b0;
        set_pc                = 1'b0;
        pc_from_register      = 1'b0;
        pc_from_irq           = 1'b0;
        pc_from_mem           = 1'b0;
        sr_from_mem           = 1'b0;
        set_sp                = 1'b0;
        increase_sp           = 1'b0;
        mem_write             = 1'b0;
        mem_write_addr_source = addr_register_data;
        mem_write_data_source = data_register_data;

        case (state_q)
            st_sample: begin
                if (take_irq) begin
                    ie_d    = 1'b0;
                    state_d = st_irq_push_pc;
                end else begin
                    state_d = st_fetch_addr;
                end
            end
            st_fetch_addr: begin
                mem_read_is_pc = 1'b1;
                state_d        = st_fetch_data;
            end
            st_fetch_data: begin
                mem_read_is_pc = 1'b1;
                state_d        = st_decode;
            end
            st_decode: begin
                case (opcode)
                    OP_LOAD:     state_d = st_load_addr;
                    OP_STORE:    state_d = st_store;
                    OP_ALU_IMM8: state_d = st_alu_imm8;
                    OP_PUSH:     state_d = st_push;
                    OP_POP:      state_d = st_pop_dec;
                    OP_ALU:      state_d = st_alu;
                    OP_ALU_IMM4: state_d = st_alu_imm4;
                    OP_JUMP:     state_d = (is_link && !is_return) ? st_jump_link_push : st_jump;
                    OP_RTI:      state_d = st_rti_dec_sr;
                    OP_EI_DI:    state_d = st_ei_di;
                    OP_HALT:     state_d = st_halt;
                    default:     state_d = st_halt;
                endcase
            end
            st_load_addr: state_d = st_load_data;
            st_load_data: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                set_pc     = 1'b1;
                state_d    = st_sample;
            end
            st_store: begin
                mem_write = 1'b1;
                set_pc    = 1'b1;
                state_d   = st_sample;
            end
            st_alu, st_alu_imm8, st_alu_imm4: begin
                reg_write         = 1'b1;
                alu_set_flags     = 1'b1;
                alu_override_imm8 = (state_q == st_alu_imm8);
                alu_override_imm4 = (state_q == st_alu_imm4);
                set_pc            = 1'b1;
                state_d           = st_sample;
            end
            st_push: begin
                mem_write             = 1'b1;
                mem_write_addr_source = addr_sp;
                state_d               = st_push_inc;
            end
            st_push_inc: begin
                set_sp      = 1'b1;
                increase_sp = 1'b1;
                set_pc      = 1'b1;
                state_d     = st_sample;
            end
            st_pop_dec: begin
                set_sp  = 1'b1;
                state_d = st_pop_addr;
            end
            st_pop_addr: begin
                mem_read_is_sp = 1'b1;
                state_d        = st_pop_data;
            end
            st_pop_data: begin
                mem_read_is_sp = 1'b1;
                reg_write      = 1'b1;
                mem_to_reg     = 1'b1;
                set_pc         = 1'b1;
                state_d        = st_sample;
            end
            st_jump: state_d = is_return ? st_jump_ret_dec : st_jump_set;
            // A failed condition keeps the cycle count but suppresses stack traffic.
            st_jump_link_push: begin
                mem_write             = taken;
                mem_write_addr_source = addr_sp;
                mem_write_data_source = data_next_pc;
                state_d               = st_jump_link_inc;
            end
            st_jump_link_inc: begin
                set_sp      = taken;
                increase_sp = taken;
                state_d     = st_jump_set;
            end
            st_jump_set: begin
                set_pc           = 1'b1;
                pc_from_register = taken;
                state_d          = st_sample;
            end
            st_jump_ret_dec: begin
                set_sp  = taken;
                state_d = st_jump_ret_addr;
            end
            st_jump_ret_addr: begin
                mem_read_is_sp = taken;
                state_d        = st_jump_ret_set;
            end
            st_jump_ret_set: begin
                set_pc         = 1'b1;
                mem_read_is_sp = taken;
                pc_from_mem    = taken;
                state_d        = st_sample;
            end
            st_ei_di: begin
                set_pc  = 1'b1;
                ie_d    = instruction[0];
                state_d = st_sample;
            end
            st_halt: begin
                if (take_irq) begin
                    ie_d    = 1'b0;
                    state_d = st_irq_push_pc;
                end
            end
            // Halt never advanced the PC, so waking must save the following address.
            st_irq_push_pc: begin
                mem_write             = 1'b1;
                mem_write_addr_source = addr_sp;
                mem_write_data_source = from_halt_q ? data_next_pc : data_this_pc;
                state_d               = st_irq_inc_pc;
            end
            st_irq_inc_pc: begin
                set_sp      = 1'b1;
                increase_sp = 1'b1;
                state_d     = st_irq_push_sr;
            end
            st_irq_push_sr: begin
                mem_write             = 1'b1;
                mem_write_addr_source = addr_sp;
                mem_write_data_source = data_sr;
                state_d               = st_irq_inc_sr;
            end
            st_irq_inc_sr: begin
                set_sp      = 1'b1;
                increase_sp = 1'b1;
                state_d     = st_irq_jmp;
            end
            st_irq_jmp: begin
                set_pc           = 1'b1;
                pc_from_register = 1'b1;
                pc_from_irq      = 1'b1;
                state_d          = st_sample;
            end
            st_rti_dec_sr: begin
                set_sp  = 1'b1;
                state_d = st_rti_addr_sr;
            end
            st_rti_addr_sr: begin
                mem_read_is_sp = 1'b1;
                state_d        = st_rti_set_sr;
            end
            st_rti_set_sr: begin
                mem_read_is_sp = 1'b1;
                sr_from_mem    = 1'b1;
                state_d        = st_rti_dec_pc;
            end
            st_rti_dec_pc: begin
                set_sp  = 1'b1;
                state_d = st_rti_addr_pc;
            end
            st_rti_addr_pc: begin
                mem_read_is_sp = 1'b1;
                state_d        = st_rti_set_pc;
            end
            st_rti_set_pc: begin
                mem_read_is_sp = 1'b1;
                pc_from_mem    = 1'b1;
                set_pc         = 1'b1;
                ie_d           = 1'b1;
                state_d        = st_sample;
            end
            default: state_d = st_sample;
        endcase
    end

    always_comb begin
        irq_ack = '0;
        if (state_q == st_irq_jmp) begin
            irq_ack[irq_id_q] = 1'b1;
        end
    end

    assign irq_id      = irq_id_q;
    assign irq_enabled = ie_q;
    assign halted      = (state_q == st_halt);
    assign state       = state_q;

endmodule

// File: tb/tb_irq_controlpath.sv
// Directed self-checking bench for irq_controlpath: instruction sequences,
// interrupt entry, priority/masking, rti, halt wake-up and mid-sequence reset.
module tb_irq_controlpath;
    import controlpath_pkg::*;

    localparam logic [14:0] RW    = 15'h4000;
    localparam logic [14:0] M2R   = 15'h2000;
    localparam logic [14:0] RDPC  = 15'h1000;
    localparam logic [14:0] RDSP  = 15'h0800;
    localparam logic [14:0] IMM8  = 15'h0400;
    localparam logic [14:0] IMM4  = 15'h0200;
    localparam logic [14:0] FLAGS = 15'h0100;
    localparam logic [14:0] SETPC = 15'h0080;
    localparam logic [14:0] PCREG = 15'h0040;
    localparam logic [14:0] PCIRQ = 15'h0020;
    localparam logic [14:0] PCMEM = 15'h0010;
    localparam logic [14:0] SRMEM = 15'h0008;
    localparam logic [14:0] SETSP = 15'h0004;
    localparam logic [14:0] INCSP = 15'h0002;
    localparam logic [14:0] MEMWR = 15'h0001;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [15:0]            instruction;
    logic                   Z, N;
    logic [3:0]             irq_req;
    logic [3:0]             irq_ack;
    logic [1:0]             irq_id;
    logic                   irq_enabled, halted;
    logic                   reg_write, mem_to_reg, mem_read_is_pc, mem_read_is_sp;
    logic                   alu_override_imm8, alu_override_imm4, alu_set_flags;
    logic                   set_pc, pc_from_register, pc_from_irq, pc_from_mem, sr_from_mem;
    logic                   set_sp, increase_sp, mem_write;
    mem_write_addr_source_t mem_write_addr_source;
    mem_write_data_source_t mem_write_data_source;
    logic [5:0]             state;

    int checks = 0;
    int errors = 0;

    irq_controlpath #(.NUM_IRQ(4)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .instruction           (instruction),
        .Z                     (Z),
        .N                     (N),
        .irq_req               (irq_req),
        .irq_ack               (irq_ack),
        .irq_id                (irq_id),
        .irq_enabled           (irq_enabled),
        .halted                (halted),
        .reg_write             (reg_write),
        .mem_to_reg            (mem_to_reg),
        .mem_read_is_pc        (mem_read_is_pc),
        .mem_read_is_sp        (mem_read_is_sp),
        .alu_override_imm8     (alu_override_imm8),
        .alu_override_imm4     (alu_override_imm4),
        .alu_set_flags         (alu_set_flags),
        .set_pc                (set_pc),
        .pc_from_register      (pc_from_register),
        .pc_from_irq           (pc_from_irq),
        .pc_from_mem           (pc_from_mem),
        .sr_from_mem           (sr_from_mem),
        .set_sp                (set_sp),
        .increase_sp           (increase_sp),
        .mem_write             (mem_write),
        .mem_write_addr_source (mem_write_addr_source),
        .mem_write_data_source (mem_write_data_source),
        .state                 (state)
    );

    always #5 clock = ~clock;

    function automatic logic [14:0] strobes();
        return {reg_write, mem_to_reg, mem_read_is_pc, mem_read_is_sp, alu_override_imm8,
                alu_override_imm4, alu_set_flags, set_pc, pc_from_register, pc_from_irq,
                pc_from_mem, sr_from_mem, set_sp, increase_sp, mem_write};
    endfunction

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // All stimulus and sampling happens 1 time unit after the falling edge.
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_state(input state_t target, input string tag);
        int k = 0;
        while (state != target && k < 100) begin
            tick();
            k++;
        end
        check(tag, 32'(state), 32'(target));
    endtask

    // Starts in st_sample; counts cycles (including st_sample) until st_sample returns.
    task automatic run_instr(input logic [15:0] instr, input logic z, input state_t probe,
                             input logic [14:0] exp_strobes, input mem_write_addr_source_t exp_addr,
                             input mem_write_data_source_t exp_data, input int exp_cycles,
                             input string tag);
        int cycles = 1;
        logic hit = 1'b0;
        logic [14:0] seen = '1;
        mem_write_addr_source_t seen_addr = addr_register_data;
        mem_write_data_source_t seen_data = data_register_data;
        Z = z;
        instruction = instr;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (state == st_sample) break;
            cycles++;
            if (state == probe) begin
                hit       = 1'b1;
                seen      = strobes();
                seen_addr = mem_write_addr_source;
                seen_data = mem_write_data_source;
            end
        end
        check({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
        check({tag, "_probe_hit"}, 32'(hit), 32'd1);
        check({tag, "_strobes"}, 32'(seen), 32'(exp_strobes));
        check({tag, "_addr_src"}, 32'(seen_addr), 32'(exp_addr));
        check({tag, "_data_src"}, 32'(seen_data), 32'(exp_data));
    endtask

    // Walks the six cycles from st_sample/st_halt through interrupt entry.
    task automatic irq_entry(input logic [1:0] exp_id, input logic [3:0] exp_ack,
                             input mem_write_data_source_t pc_src, input string tag);
        tick();
        check({tag, "_s1"}, 32'(state), 32'(st_irq_push_pc));
        check({tag, "_s1_strobes"}, 32'(strobes()), 32'(MEMWR));
        check({tag, "_s1_addr"}, 32'(mem_write_addr_source), 32'(addr_sp));
        check({tag, "_s1_data"}, 32'(mem_write_data_source), 32'(pc_src));
        check({tag, "_id"}, 32'(irq_id), 32'(exp_id));
        check({tag, "_ie_cleared"}, 32'(irq_enabled), 32'd0);
        check({tag, "_s1_ack"}, 32'(irq_ack), 32'd0);
        tick();
        check({tag, "_s2"}, 32'(state), 32'(st_irq_inc_pc));
        check({tag, "_s2_strobes"}, 32'(strobes()), 32'(SETSP | INCSP));
        tick();
        check({tag, "_s3"}, 32'(state), 32'(st_irq_push_sr));
        check({tag, "_s3_strobes"}, 32'(strobes()), 32'(MEMWR));
        check({tag, "_s3_data"}, 32'(mem_write_data_source), 32'(data_sr));
        tick();
        check({tag, "_s4_strobes"}, 32'(strobes()), 32'(SETSP | INCSP));
        check({tag, "_s4_ack"}, 32'(irq_ack), 32'd0);
        tick();
        check({tag, "_s5"}, 32'(state), 32'(st_irq_jmp));
        check({tag, "_s5_strobes"}, 32'(strobes()), 32'(SETPC | PCREG | PCIRQ));
        check({tag, "_s5_ack"}, 32'(irq_ack), 32'(exp_ack));
        tick();
        check({tag, "_s6"}, 32'(state), 32'(st_sample));
        check({tag, "_s6_ack"}, 32'(irq_ack), 32'd0);
    endtask

    task automatic exec_ei(input string tag);
        instruction = 16'hC001;
        wait_state(st_ei_di, {tag, "_reach"});
        check({tag, "_ie_before"}, 32'(irq_enabled), 32'd0);
        tick();
        check({tag, "_sample"}, 32'(state), 32'(st_sample));
        check({tag, "_ie_after"}, 32'(irq_enabled), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int count;
        logic [14:0] rti_strobes [10];
        state_t      rti_states  [10];

        reset = 1'b1; instruction = 16'h8000; Z = 1'b0; N = 1'b0; irq_req = 4'b0000;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_state", 32'(state), 32'(st_sample));
        check("rst_ie", 32'(irq_enabled), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_strobes", 32'(strobes()), 32'd0);
        check("rst_ack", 32'(irq_ack), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        run_instr(16'h8000, 1'b0, st_alu, RW | FLAGS | SETPC, addr_register_data, data_register_data, 5, "alu");
        run_instr(16'h2000, 1'b0, st_alu_imm8, RW | IMM8 | FLAGS | SETPC, addr_register_data, data_register_data, 5, "alu_imm8");
        run_instr(16'h9000, 1'b0, st_alu_imm4, RW | IMM4 | FLAGS | SETPC, addr_register_data, data_register_data, 5, "alu_imm4");
        run_instr(16'h1000, 1'b0, st_store, MEMWR | SETPC, addr_register_data, data_register_data, 5, "store");
        run_instr(16'h0000, 1'b0, st_load_data, RW | M2R | SETPC, addr_register_data, data_register_data, 6, "load");
        run_instr(16'h5000, 1'b0, st_push, MEMWR, addr_sp, data_register_data, 6, "push");
        run_instr(16'h6000, 1'b0, st_pop_data, RW | M2R | RDSP | SETPC, addr_register_data, data_register_data, 7, "pop");
        run_instr(16'h0000, 1'b0, st_fetch_data, RDPC, addr_register_data, data_register_data, 6, "fetch");
        run_instr(16'hA001, 1'b0, st_jump_set, SETPC, addr_register_data, data_register_data, 6, "jz_not_taken");
        run_instr(16'hA001, 1'b1, st_jump_set, SETPC | PCREG, addr_register_data, data_register_data, 6, "jz_taken");
        run_instr(16'hA002, 1'b1, st_jump_set, SETPC, addr_register_data, data_register_data, 6, "jnz_not_taken");
        run_instr(16'hA010, 1'b0, st_jump_link_push, MEMWR, addr_sp, data_next_pc, 7, "jmpl");
        run_instr(16'hA020, 1'b0, st_jump_ret_set, RDSP | PCMEM | SETPC, addr_register_data, data_register_data, 8, "jret");
        run_instr(16'hC000, 1'b0, st_ei_di, SETPC, addr_register_data, data_register_data, 5, "di");

        instruction = 16'hA010;
        wait_state(st_jump_link_inc, "jmpl_inc_reach");
        check("jmpl_inc_strobes", 32'(strobes()), 32'(SETSP | INCSP));
        tick();
        check("jmpl_set_state", 32'(state), 32'(st_jump_set));
        check("jmpl_set_strobes", 32'(strobes()), 32'(SETPC | PCREG));
        wait_state(st_sample, "jmpl_done");

        // Masked request: no entry while IE=0, then taken after ei.
        irq_req = 4'b1000;
        instruction = 16'h8000;
        count = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (state == st_irq_push_pc || irq_ack != 4'b0000) count++;
        end
        check("masked_no_entry", 32'(count), 32'd0);
        wait_state(st_sample, "masked_sample");
        exec_ei("ei1");
        irq_entry(2'd3, 4'b1000, data_this_pc, "irq3");
        irq_req = 4'b0000;

        // Two simultaneous requests: lowest index wins, the other stays pending.
        irq_req = 4'b0110;
        exec_ei("ei2");
        irq_entry(2'd1, 4'b0010, data_this_pc, "irq1");
        irq_req = 4'b0100;

        rti_states  = '{st_fetch_addr, st_fetch_data, st_decode, st_rti_dec_sr, st_rti_addr_sr,
                        st_rti_set_sr, st_rti_dec_pc, st_rti_addr_pc, st_rti_set_pc, st_sample};
        rti_strobes = '{RDPC, RDPC, 15'h0000, SETSP, RDSP, RDSP | SRMEM, SETSP, RDSP,
                        RDSP | PCMEM | SETPC, 15'h0000};
        instruction = 16'hB000;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("rti_state%0d", k), 32'(state), 32'(rti_states[k]));
            check($sformatf("rti_strobes%0d", k), 32'(strobes()), 32'(rti_strobes[k]));
        end
        check("rti_ie_restored", 32'(irq_enabled), 32'd1);
        irq_entry(2'd2, 4'b0100, data_this_pc, "irq2");
        irq_req = 4'b0000;

        // Halt with IE=1 wakes on a request and saves next_pc.
        exec_ei("ei3");
        instruction = 16'h7000;
        wait_state(st_halt, "halt_reach");
        count = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (halted && strobes() == 15'h0000) count++;
        end
        check("halt_idle", 32'(count), 32'd5);
        irq_req = 4'b0001;
        irq_entry(2'd0, 4'b0001, data_next_pc, "wake");
        irq_req = 4'b0000;

        // Halt with IE=0 ignores requests.
        instruction = 16'h7000;
        wait_state(st_halt, "halt2_reach");
        irq_req = 4'b0001;
        count = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (state == st_halt) count++;
        end
        check("halt_masked", 32'(count), 32'd50);
        irq_req = 4'b0000;

        // Reset mid-push abandons the sequence and clears IE.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exec_ei("ei4");
        instruction = 16'h5000;
        wait_state(st_push, "push_reach");
        reset = 1'b1;
        tick();
        check("rst_push_strobes1", 32'(strobes()), 32'd0);
        tick();
        check("rst_push_strobes2", 32'(strobes()), 32'd0);
        reset = 1'b0;
        check("rst_push_state", 32'(state), 32'(st_sample));
        check("rst_push_ie", 32'(irq_enabled), 32'd0);
        tick();
        check("rst_push_fetch", 32'(state), 32'(st_fetch_addr));
        check("rst_push_no_write", 32'(mem_write | set_sp), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
